calc_accumulator: RTL

Parametrised successor of the simple-calculator button-action block. It holds a WIDTH-bit running total and applies add, subtract, multiply or divide using the switch operand, one operation per rising button edge. Multiply and divide are iterative, sequential engines built into the block. The block adds signed/unsigned mode, a sticky error flag, a busy/done handshake and clear/abort. It sits between the board switch/button inputs and the seven-segment display driver.

---
 rtl/calc_accumulator.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/calc_accumulator.sv
// calc_accumulator: switch/button calculator with a running total, an
// iterative shift-add multiplier / restoring divider, sticky error and busy/done.
module calc_accumulator #(
  parameter int WIDTH  = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] operand,
  input  logic             btn_add,
  input  logic             btn_sub,
  input  logic             btn_mul,
  input  logic             btn_div,
  input  logic             btn_mode,
  input  logic             btn_clr,
  output logic [WIDTH-1:0] total,
  output logic [WIDTH-1:0] disp,
  output logic             edit,
  output logic             busy,
  output logic             err,
  output logic             done
);
  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_e;

  state_e           state_q, state_d;
  logic [5:0]       btn_in, b_r_q, b_rr_q, rise;
  logic             rs_add, rs_sub, rs_mul, rs_div, rs_mode, rs_clr;
  logic [W-1:0]     total_q, total_d;
  logic             err_q, err_d, edit_q, edit_d, done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*W-1:0]   acc_q, acc_d, sh_q, sh_d;
  logic [W-1:0]     q_q, q_d;
  logic             neg_q, neg_d;
  logic             last;

  assign btn_in = {btn_clr, btn_mode, btn_div, btn_mul, btn_sub, btn_add};
  assign rise   = b_r_q & ~b_rr_q;
  assign {rs_clr, rs_mode, rs_div, rs_mul, rs_sub, rs_add} = rise;
  assign last   = (cnt_q == CW'(W-1));

  logic             t_neg, o_neg, op_zero;
  logic [W-1:0]     t_mag, o_mag;
  logic [W:0]       sum, dif;
  logic             add_ovf, sub_ovf;

  assign t_neg   = SIGNED & total_q[W-1];
  assign o_neg   = SIGNED & operand[W-1];
  assign t_mag   = t_neg ? -total_q : total_q;
  assign o_mag   = o_neg ? -operand : operand;
  assign op_zero = (operand == '0);
  assign sum     = {1'b0, total_q} + {1'b0, operand};
  assign dif     = {1'b0, total_q} - {1'b0, operand};
  assign add_ovf = SIGNED ? ((total_q[W-1] == operand[W-1]) &&
                             (sum[W-1] != total_q[W-1])) : sum[W];
  assign sub_ovf = SIGNED ? ((total_q[W-1] != operand[W-1]) &&
                             (dif[W-1] != total_q[W-1])) : dif[W];

  // Engines work on magnitudes; the sign is reapplied on the final step.
  logic [2*W-1:0]   acc_nx, half;
  logic [W-1:0]     prod, qn, quot;
  logic [W:0]       r_sh, rdiff;
  logic             ge, mul_ovf, div_ovf;

  assign half    = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};
  assign acc_nx  = acc_q + (q_q[0] ? sh_q : '0);
  assign prod    = neg_q ? -acc_nx[W-1:0] : acc_nx[W-1:0];
  assign mul_ovf = SIGNED ? (neg_q ? (acc_nx > half) : (acc_nx >= half))
                          : |acc_nx[2*W-1:W];
  assign r_sh    = {acc_q[W-1:0], q_q[W-1]};
  assign rdiff   = r_sh - {1'b0, sh_q[W-1:0]};
  assign ge      = ~rdiff[W];
  assign qn      = {q_q[W-2:0], ge};
  assign quot    = neg_q ? -qn : qn;
  assign div_ovf = SIGNED & ~neg_q & qn[W-1];

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rs_clr) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (rs_add || rs_sub)          state_d = S_IDLE;
          else if (rs_mul)               state_d = S_MUL;
          else if (rs_div && !op_zero)   state_d = S_DIV;
        end
        S_MUL, S_DIV: if (last) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    total_d = total_q;
    err_d   = err_q;
    edit_d  = edit_q ^ rs_mode;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    q_d     = q_q;
    neg_d   = neg_q;
    if (rs_clr) begin
      total_d = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          acc_d = '0;
          neg_d = t_neg ^ o_neg;
          if (rs_add) begin
            total_d = sum[W-1:0];
            err_d   = err_q | add_ovf;
            done_d  = 1'b1;
          end else if (rs_sub) begin
            total_d = dif[W-1:0];
            err_d   = err_q | sub_ovf;
            done_d  = 1'b1;
          end else if (rs_mul) begin
            sh_d = {{W{1'b0}}, t_mag};
            q_d  = o_mag;
          end else if (rs_div) begin
            if (op_zero) begin
              err_d  = 1'b1;
              done_d = 1'b1;
            end else begin
              sh_d = {{W{1'b0}}, o_mag};
              q_d  = t_mag;
            end
          end
        end
        S_MUL: begin
          acc_d = acc_nx;
          sh_d  = sh_q << 1;
          q_d   = q_q >> 1;
          cnt_d = cnt_q + CW'(1);
          if (last) begin
            total_d = prod;
            err_d   = err_q | mul_ovf;
            done_d  = 1'b1;
          end
        end
        S_DIV: begin
          acc_d = {{W{1'b0}}, ge ? rdiff[W-1:0] : r_sh[W-1:0]};
          q_d   = qn;
          cnt_d = cnt_q + CW'(1);
          if (last) begin
            total_d = quot;
            err_d   = err_q | div_ovf;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_r_q   <= '0;
      b_rr_q  <= '0;
      total_q <= '0;
      err_q   <= 1'b0;
      edit_q  <= 1'b1;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      q_q     <= '0;
      neg_q   <= 1'b0;
    end else begin
      b_r_q   <= btn_in;
      b_rr_q  <= b_r_q;
      total_q <= total_d;
      err_q   <= err_d;
      edit_q  <= edit_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      q_q     <= q_d;
      neg_q   <= neg_d;
    end
  end

  always_comb begin
    total = total_q;
    disp  = edit_q ? operand : total_q;
    edit  = edit_q;
    busy  = (state_q != S_IDLE);
    err   = err_q;
    done  = done_q;
  end

endmodule
